sram_ctrl: RTL and testbench

Data-memory controller between the `openmips` core's data port and an external 16-bit asynchronous SRAM. It is the downstream replacement for the on-chip data RAM in board builds. Each 32-bit core access becomes one or two timed 16-bit SRAM cycles. The core is held in its MEM stage through `stallreq_o` until the access completes.

---
 rtl/sram_ctrl_pkg.sv | 29 ++
 rtl/sram_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the data-memory SRAM controller: state encoding,
// halfword width and byte-select to phase decode helpers.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PH_HI = 2'd1,
        PH_LO = 2'd2,
        DONE  = 2'd3
    } sram_state_e;

    localparam int HALF_W = 16;

    function automatic logic sel_has_hi(input logic [3:0] sel);
        return |sel[3:2];
    endfunction

    function automatic logic sel_has_lo(input logic [3:0] sel);
        return |sel[1:0];
    endfunction

    // First phase of an access; a zero select skips the SRAM entirely.
    function automatic sram_state_e first_phase(input logic [3:0] sel);
        if (sel_has_hi(sel)) return PH_HI;
        if (sel_has_lo(sel)) return PH_LO;
        return DONE;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Turns each 32-bit core data access into one or two timed 16-bit cycles on
// an asynchronous SRAM, stalling the core's MEM stage until the access ends.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ram_ce_i,
    input  logic                ram_we_i,
    input  logic [31:0]         ram_addr_i,
    input  logic [3:0]          ram_sel_i,
    input  logic [31:0]         ram_data_i,
    output logic [31:0]         ram_data_o,
    output logic                stallreq_o,
    output logic [SRAM_AW-1:0]  sram_addr_o,
    output logic [HALF_W-1:0]   sram_data_o,
    input  logic [HALF_W-1:0]   sram_data_i,
    output logic                sram_data_oe_o,
    output logic                sram_ce_n_o,
    output logic                sram_oe_n_o,
    output logic                sram_we_n_o,
    output logic                sram_ub_n_o,
    output logic                sram_lb_n_o,
    output sram_state_e         dbg_state
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
    localparam int WORD_W = SRAM_AW - 1;

    sram_state_e        state_q, state_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic               we_q, we_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rd_buf_q, rd_buf_d;
    logic [31:0]        ram_data_d;
    logic [SRAM_AW-1:0] addr_d;
    logic [HALF_W-1:0]  data_d;
    logic               ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, data_oe_d;
    logic               phase_end, in_hi, in_lo, in_ph;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_addr_i[31:SRAM_AW+1], ram_addr_i[1:0]};

    // Request handshake: ram_ce_i is the request; stallreq_o high means "not
    // done yet", and the cycle it drops (DONE) completes the access.
    assign stallreq_o = ((state_q == IDLE) && ram_ce_i) ||
                        (state_q == PH_HI) || (state_q == PH_LO);
    assign dbg_state  = state_q;
    assign phase_end  = (wait_q == LAST);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        we_d       = we_q;
        word_d     = word_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        rd_buf_d   = rd_buf_q;
        ram_data_d = ram_data_o;
        case (state_q)
            IDLE: begin
                if (ram_ce_i) begin
                    we_d     = ram_we_i;
                    word_d   = ram_addr_i[SRAM_AW:2];
                    sel_d    = ram_sel_i;
                    wdata_d  = ram_data_i;
                    rd_buf_d = '0;
                    wait_d   = '0;
                    state_d  = first_phase(ram_sel_i);
                end
            end
            PH_HI: begin
                if (phase_end) begin
                    wait_d = '0;
                    if (!we_q) rd_buf_d[31:16] = sram_data_i;
                    state_d = sel_has_lo(sel_q) ? PH_LO : DONE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            PH_LO: begin
                if (phase_end) begin
                    wait_d = '0;
                    if (!we_q) rd_buf_d[15:0] = sram_data_i;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == DONE) && !we_d) ram_data_d = rd_buf_d;

        // Pad outputs are registered from the next-state view so strobes
        // switch exactly on state boundaries.
        in_hi     = (state_d == PH_HI);
        in_lo     = (state_d == PH_LO);
        in_ph     = in_hi || in_lo;
        addr_d    = sram_addr_o;
        data_d    = sram_data_o;
        if (in_ph) begin
            addr_d = {word_d, in_lo};
            data_d = in_hi ? wdata_d[31:16] : wdata_d[15:0];
        end
        ce_n_d    = !in_ph;
        oe_n_d    = !(in_ph && !we_d);
        data_oe_d = in_ph && we_d;
        we_n_d    = !(in_ph && we_d && (wait_d != LAST));
        ub_n_d    = !((in_hi && sel_d[3]) || (in_lo && sel_d[1]));
        lb_n_d    = !((in_hi && sel_d[2]) || (in_lo && sel_d[0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            we_q           <= 1'b0;
            word_q         <= '0;
            sel_q          <= '0;
            wdata_q        <= '0;
            rd_buf_q       <= '0;
            ram_data_o     <= '0;
            sram_addr_o    <= '0;
            sram_data_o    <= '0;
            sram_data_oe_o <= 1'b0;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_ub_n_o    <= 1'b1;
            sram_lb_n_o    <= 1'b1;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            we_q           <= we_d;
            word_q         <= word_d;
            sel_q          <= sel_d;
            wdata_q        <= wdata_d;
            rd_buf_q       <= rd_buf_d;
            ram_data_o     <= ram_data_d;
            sram_addr_o    <= addr_d;
            sram_data_o    <= data_d;
            sram_data_oe_o <= data_oe_d;
            sram_ce_n_o    <= ce_n_d;
            sram_oe_n_o    <= oe_n_d;
            sram_we_n_o    <= we_n_d;
            sram_ub_n_o    <= ub_n_d;
            sram_lb_n_o    <= lb_n_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a small asynchronous SRAM model on the pads
// and one task per scenario with hand-computed expectations.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_ce_i = 1'b0;
    logic        ram_we_i = 1'b0;
    logic [31:0] ram_addr_i = '0;
    logic [3:0]  ram_sel_i = '0;
    logic [31:0] ram_data_i = '0;
    logic [31:0] ram_data_o;
    logic        stallreq_o;
    logic [19:0] sram_addr_o;
    logic [15:0] sram_data_o;
    logic [15:0] sram_data_i;
    logic        sram_data_oe_o;
    logic        sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o;
    sram_state_e dbg_state;

    logic [15:0] mem [0:63];
    int n_cmp = 0;
    int n_bad = 0;

    // Per-access observations filled by do_access
    int          n_stall, n_ce_low, n_oe_low, n_we_low, n_strobe;
    logic [7:0]  we_seq;
    logic [19:0] seen_addr;
    logic        seen_ub_n, seen_lb_n, seen_any;
    sram_state_e st_first, st_second;
    logic [31:0] rd_at_start;

    sram_ctrl dut (
        .clk(clk), .rst(rst),
        .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_addr_i(ram_addr_i),
        .ram_sel_i(ram_sel_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
        .stallreq_o(stallreq_o), .sram_addr_o(sram_addr_o),
        .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
        .sram_data_oe_o(sram_data_oe_o), .sram_ce_n_o(sram_ce_n_o),
        .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
        .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // SRAM model: combinational read, level-sensitive byte-lane write
    assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[5:0]] : 16'hDEAD;

    always @(negedge clk) begin
        if (!sram_ce_n_o && !sram_we_n_o) begin
            if (!sram_ub_n_o) mem[sram_addr_o[5:0]][15:8] = sram_data_o[15:8];
            if (!sram_lb_n_o) mem[sram_addr_o[5:0]][7:0]  = sram_data_o[7:0];
        end
    end

    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata,
                             input bit hold);
        int n;
        @(negedge clk);
        ram_ce_i = 1'b1; ram_we_i = we; ram_addr_i = addr;
        ram_sel_i = sel; ram_data_i = wdata;
        #1;
        n = 0; n_ce_low = 0; n_oe_low = 0; n_we_low = 0; n_strobe = 0;
        we_seq = '0; seen_any = 1'b0; seen_addr = '0;
        seen_ub_n = 1'b1; seen_lb_n = 1'b1;
        st_first = dbg_state; st_second = dbg_state; rd_at_start = ram_data_o;
        while (stallreq_o && n < 50) begin
            if (n == 1) st_second = dbg_state;
            if (!sram_ce_n_o) begin
                n_ce_low++;
                we_seq = {we_seq[6:0], sram_we_n_o};
                if (!seen_any) begin
                    seen_any = 1'b1; seen_addr = sram_addr_o;
                    seen_ub_n = sram_ub_n_o; seen_lb_n = sram_lb_n_o;
                end
            end
            if (!sram_oe_n_o) n_oe_low++;
            if (!sram_we_n_o) n_we_low++;
            if (!sram_ce_n_o || !sram_oe_n_o || !sram_we_n_o || !sram_ub_n_o ||
                !sram_lb_n_o || sram_data_oe_o) n_strobe++;
            n++;
            @(negedge clk);
            #1;
        end
        n_stall = n;
        if (n >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL access_timeout: stall still high after %0d cycles, required to drop", n);
        end
        if (!hold) ram_ce_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; ram_ce_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o} !== 5'b11111) begin
            n_bad++; $display("FAIL reset_strobes: got %b required 11111",
                {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o});
        end
        n_cmp++; if (sram_data_oe_o !== 1'b0) begin n_bad++; $display("FAIL reset_data_oe: got %b required 0", sram_data_oe_o); end
        n_cmp++; if (sram_addr_o !== 20'h0) begin n_bad++; $display("FAIL reset_addr: got %h required 0", sram_addr_o); end
        n_cmp++; if (sram_data_o !== 16'h0) begin n_bad++; $display("FAIL reset_sram_data: got %h required 0", sram_data_o); end
        n_cmp++; if (ram_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_ram_data: got %h required 0", ram_data_o); end
        n_cmp++; if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b required 0", stallreq_o); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_word_read;
        mem[8] = 16'hAABB; mem[9] = 16'hCCDD;
        do_access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1'b0);
        n_cmp++; if (n_stall !== 5) begin n_bad++; $display("FAIL word_read_stall: got %0d required 5", n_stall); end
        n_cmp++; if (ram_data_o !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL word_read_data: got %h required aabbccdd", ram_data_o); end
        n_cmp++; if (n_oe_low !== 4) begin n_bad++; $display("FAIL word_read_oe: got %0d required 4", n_oe_low); end
        n_cmp++; if (n_we_low !== 0) begin n_bad++; $display("FAIL word_read_we: got %0d required 0", n_we_low); end
        n_cmp++; if (seen_addr !== 20'd8) begin n_bad++; $display("FAIL word_read_addr: got %0d required 8", seen_addr); end
    endtask

    task automatic test_byte_write;
        mem[3] = 16'h5566;
        do_access(1'b1, 32'h0000_0007, 4'b0001, 32'h0000_00EE, 1'b0);
        n_cmp++; if (n_stall !== 3) begin n_bad++; $display("FAIL byte_write_stall: got %0d required 3", n_stall); end
        n_cmp++; if (n_ce_low !== 2) begin n_bad++; $display("FAIL byte_write_ce: got %0d required 2", n_ce_low); end
        n_cmp++; if (seen_addr !== 20'd3) begin n_bad++; $display("FAIL byte_write_addr: got %0d required 3", seen_addr); end
        n_cmp++; if ({seen_ub_n, seen_lb_n} !== 2'b10) begin n_bad++; $display("FAIL byte_write_lanes: got %b required 10", {seen_ub_n, seen_lb_n}); end
        n_cmp++; if (we_seq[1:0] !== 2'b01) begin n_bad++; $display("FAIL byte_write_we_seq: got %b required 01", we_seq[1:0]); end
        n_cmp++; if (mem[3] !== 16'h55EE) begin n_bad++; $display("FAIL byte_write_mem: got %h required 55ee", mem[3]); end
        n_cmp++; if (ram_data_o !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL byte_write_rdata_hold: got %h required aabbccdd", ram_data_o); end
    endtask

    task automatic test_half_write;
        mem[16] = 16'h0000; mem[17] = 16'h7777;
        do_access(1'b1, 32'h0000_0020, 4'b1100, 32'h1234_0000, 1'b0);
        n_cmp++; if (n_stall !== 3) begin n_bad++; $display("FAIL half_write_stall: got %0d required 3", n_stall); end
        n_cmp++; if (seen_addr !== 20'd16) begin n_bad++; $display("FAIL half_write_addr: got %0d required 16", seen_addr); end
        n_cmp++; if (mem[16] !== 16'h1234) begin n_bad++; $display("FAIL half_write_mem_hi: got %h required 1234", mem[16]); end
        n_cmp++; if (mem[17] !== 16'h7777) begin n_bad++; $display("FAIL half_write_mem_lo: got %h required 7777", mem[17]); end
    endtask

    task automatic test_partial_read;
        do_access(1'b0, 32'h0000_0010, 4'b0011, 32'h0, 1'b0);
        n_cmp++; if (n_stall !== 3) begin n_bad++; $display("FAIL lo_read_stall: got %0d required 3", n_stall); end
        n_cmp++; if (ram_data_o !== 32'h0000_CCDD) begin n_bad++; $display("FAIL lo_read_data: got %h required 0000ccdd", ram_data_o); end
    endtask

    task automatic test_zero_sel;
        do_access(1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        n_cmp++; if (n_stall !== 1) begin n_bad++; $display("FAIL zero_sel_stall: got %0d required 1", n_stall); end
        n_cmp++; if (n_strobe !== 0) begin n_bad++; $display("FAIL zero_sel_strobes: got %0d active cycles required 0", n_strobe); end
        n_cmp++; if (mem[8] !== 16'hAABB) begin n_bad++; $display("FAIL zero_sel_mem: got %h required aabb", mem[8]); end
        n_cmp++; if (ram_data_o !== 32'h0000_CCDD) begin n_bad++; $display("FAIL zero_sel_rdata_hold: got %h required 0000ccdd", ram_data_o); end
    endtask

    task automatic test_reset_mid_write;
        mem[40] = 16'h1111; mem[41] = 16'h2222;
        @(negedge clk);
        ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_addr_i = 32'h0000_0050;
        ram_sel_i = 4'b1111; ram_data_i = 32'hABCD_EF01;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (dbg_state !== PH_HI) begin n_bad++; $display("FAIL rst_mid_pre_state: got %0d required %0d", dbg_state, PH_HI); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o} !== 5'b11111) begin
            n_bad++; $display("FAIL rst_mid_strobes: got %b required 11111",
                {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o});
        end
        n_cmp++; if (sram_data_oe_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_data_oe: got %b required 0", sram_data_oe_o); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rst_mid_state: got %0d required %0d", dbg_state, IDLE); end
        rst = 1'b0; ram_ce_i = 1'b0; ram_we_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: got %b required 0", stallreq_o); end
        n_cmp++; if (mem[41] !== 16'h2222) begin n_bad++; $display("FAIL rst_mid_lo_mem: got %h required 2222", mem[41]); end
        n_cmp++; if (mem[40] !== 16'hABCD) begin n_bad++; $display("FAIL rst_mid_hi_mem: got %h required abcd", mem[40]); end
    endtask

    task automatic test_back_to_back;
        do_access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1'b1);
        n_cmp++; if (n_stall !== 5) begin n_bad++; $display("FAIL b2b_first_stall: got %0d required 5", n_stall); end
        n_cmp++; if (ram_data_o !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL b2b_first_data: got %h required aabbccdd", ram_data_o); end
        do_access(1'b0, 32'h0000_0020, 4'b1111, 32'h0, 1'b0);
        n_cmp++; if (st_first !== IDLE) begin n_bad++; $display("FAIL b2b_gap_idle: got %0d required %0d", st_first, IDLE); end
        n_cmp++; if (st_second !== PH_HI) begin n_bad++; $display("FAIL b2b_then_hi: got %0d required %0d", st_second, PH_HI); end
        n_cmp++; if (rd_at_start !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL b2b_rdata_hold: got %h required aabbccdd", rd_at_start); end
        n_cmp++; if (n_stall !== 5) begin n_bad++; $display("FAIL b2b_second_stall: got %0d required 5", n_stall); end
        n_cmp++; if (ram_data_o !== 32'h1234_7777) begin n_bad++; $display("FAIL b2b_second_data: got %h required 12347777", ram_data_o); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
        test_reset();
        test_word_read();
        test_byte_write();
        test_half_write();
        test_partial_read();
        test_zero_sel();
        test_reset_mid_write();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
